// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined adder with lower-part-OR approximation on the low APPROX_BITS,
// per-transaction exact/approximate selection and a running error monitor.
module approx_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic [WIDTH:0]       err_dist,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [WIDTH:0]       max_err
);

    localparam int RW = WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]        RW_ZERO  = {RW{1'b0}};

    function automatic logic [RW-1:0] abs_diff(input logic [RW-1:0] x, input logic [RW-1:0] y);
        abs_diff = (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
        sat_inc = (x == CNT_MAX) ? x : (x + CNT_ONE);
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic                 s1_cin_q, s1_cin_d;
    logic                 s1_approx_q, s1_approx_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic [RW-1:0]        err_q, err_d;

    logic [CNT_WIDTH-1:0] sample_count_q, sample_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic [RW-1:0]        max_err_q, max_err_d;

    logic                 adv2_s;
    logic                 accept_s;
    logic                 deliver_s;
    logic [RW-1:0]        exact_s;
    logic [RW-1:0]        approx_s;
    logic [RW-1:0]        result_s;

    // Handshake: S1 drains into S2 whenever S2 is empty or being consumed.
    always_comb begin
        adv2_s    = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready  = ~s1_valid_q | adv2_s;
        accept_s  = in_valid & in_ready;
        deliver_s = s2_valid_q & out_ready;
    end

    // Reference sum of the S1 operands, always including cin.
    always_comb begin
        exact_s = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
    end

    generate
        if (APPROX_BITS > 0) begin : g_approx
            logic [APPROX_BITS-1:0]     low_s;
            logic                       carry_s;
            logic [WIDTH-APPROX_BITS:0] high_s;

            // Low bits are ORed; only the top approximated bit pair predicts a carry.
            always_comb begin
                low_s    = s1_a_q[APPROX_BITS-1:0] | s1_b_q[APPROX_BITS-1:0];
                carry_s  = s1_a_q[APPROX_BITS-1] & s1_b_q[APPROX_BITS-1];
                high_s   = {1'b0, s1_a_q[WIDTH-1:APPROX_BITS]}
                         + {1'b0, s1_b_q[WIDTH-1:APPROX_BITS]}
                         + {{(WIDTH-APPROX_BITS){1'b0}}, carry_s};
                approx_s = {high_s, low_s};
            end
        end else begin : g_exact
            // No approximated bits: both modes collapse to the exact sum.
            always_comb begin
                approx_s = exact_s;
            end
        end
    endgenerate

    // Mode selection uses the approx_en captured alongside the operands.
    always_comb begin
        if (s1_approx_q) begin
            result_s = approx_s;
        end else begin
            result_s = exact_s;
        end
    end

    // Stage 1 next state: load on accept, empty when drained without refill.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s1_approx_d = s1_approx_q;
        if (accept_s) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = a;
            s1_b_d      = b;
            s1_cin_d    = cin;
            s1_approx_d = approx_en;
        end else if (adv2_s) begin
            s1_valid_d  = 1'b0;
        end else begin
            s1_valid_d  = s1_valid_q;
        end
    end

    // Stage 2 next state: result and error distance held while stalled.
    always_comb begin
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        err_d      = err_q;
        if (adv2_s) begin
            s2_valid_d     = 1'b1;
            {cout_d, sum_d} = result_s;
            err_d          = abs_diff(result_s, exact_s);
        end else if (deliver_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Statistics: a clear in a delivery cycle restarts from that single result.
    always_comb begin
        sample_count_d = stat_clear ? CNT_ZERO : sample_count_q;
        err_count_d    = stat_clear ? CNT_ZERO : err_count_q;
        max_err_d      = stat_clear ? RW_ZERO  : max_err_q;
        if (deliver_s) begin
            sample_count_d = sat_inc(sample_count_d);
            if (err_q != RW_ZERO) begin
                err_count_d = sat_inc(err_count_d);
            end else begin
                err_count_d = err_count_d;
            end
            if (err_q > max_err_d) begin
                max_err_d = err_q;
            end else begin
                max_err_d = max_err_d;
            end
        end else begin
            sample_count_d = sample_count_d;
        end
    end

    // Pipeline and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_a_q         <= {WIDTH{1'b0}};
            s1_b_q         <= {WIDTH{1'b0}};
            s1_cin_q       <= 1'b0;
            s1_approx_q    <= 1'b0;
            s2_valid_q     <= 1'b0;
            sum_q          <= {WIDTH{1'b0}};
            cout_q         <= 1'b0;
            err_q          <= RW_ZERO;
            sample_count_q <= CNT_ZERO;
            err_count_q    <= CNT_ZERO;
            max_err_q      <= RW_ZERO;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_a_q         <= s1_a_d;
            s1_b_q         <= s1_b_d;
            s1_cin_q       <= s1_cin_d;
            s1_approx_q    <= s1_approx_d;
            s2_valid_q     <= s2_valid_d;
            sum_q          <= sum_d;
            cout_q         <= cout_d;
            err_q          <= err_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            max_err_q      <= max_err_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign err_dist     = err_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_err      = max_err_q;

endmodule
